// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional parity bit, 1 or 2 stop bits. Bit timing comes from a shared
// oversample strobe (b_tick), OVERSAMPLE strobes per bit period.
// Optional feature macro: UART_TX_HOLD_EN adds a one-word holding register
// and a tx_ready output so frames can be chained with no idle cycle.
module uart_tx_frame #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 b_tick,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
`ifdef UART_TX_HOLD_EN
    ,
    output logic                 tx_ready
`endif
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 4 || OVERSAMPLE > 32 ||
            PARITY_MODE < 0 || PARITY_MODE > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
            $error("uart_tx_frame: illegal parameter value");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 bit_end;
`ifdef UART_TX_HOLD_EN
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 ready_q, ready_d;
`endif

    // Parity bit of a word; odd parity is the inverse of the XOR reduction.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] w);
        return (PARITY_MODE == 2) ? ~(^w) : ^w;
    endfunction

    // Next-state logic; outputs are derived from the next state so they register cleanly.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        par_d   = par_q;
        done_d  = 1'b0;
        tx_d    = 1'b1;
        bit_end = b_tick && (tick_q == TICK_LAST);
`ifdef UART_TX_HOLD_EN
        hold_d  = hold_q;
        ready_d = ready_q;
`endif
        // Ticks only count inside a frame; the accept cycle's tick is dropped.
        if (state_q != IDLE && b_tick)
            tick_d = bit_end ? '0 : tick_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = START;
                    shift_d = tx_data;
                    par_d   = parity_of(tx_data);
                    tick_d  = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY_MODE != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    if (STOP_BITS == 2 && !stop_q) begin
                        stop_d = 1'b1;
                    end else begin
                        stop_d  = 1'b0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef UART_TX_HOLD_EN
        // A held word restarts the frame straight from STOP; a start arriving
        // on the frame-end cycle itself is left for the following IDLE cycle.
        if (done_d && !ready_q) begin
            state_d = START;
            shift_d = hold_q;
            par_d   = parity_of(hold_q);
            tick_d  = '0;
            ready_d = 1'b1;
        end else if (start && state_q != IDLE && ready_q && !done_d) begin
            hold_d  = tx_data;
            ready_d = 1'b0;
        end
`endif

        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d;
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; rst aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_HOLD_EN
            hold_q  <= '0;
            ready_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UART_TX_HOLD_EN
            hold_q  <= hold_d;
            ready_q <= ready_d;
`endif
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;
`ifdef UART_TX_HOLD_EN
    assign tx_ready = ready_q;
`endif

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three instances (8N1/16x, 8O2/16x, 7N1/8x with
// gapped ticks) driven by a vector table, plus hand sequences for busy,
// abort, back-to-back and (with UART_TX_HOLD_EN) held-word chaining.
module tb_uart_tx_frame;

    logic       clk;
    logic       rst;
    logic [2:0] st;
    logic [2:0] bt;
    logic [8:0] dat;
    logic [2:0] txv, busyv, donev;
`ifdef UART_TX_HOLD_EN
    logic       rdy0, rdy1, rdy2;
`endif

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_frame #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .b_tick(bt[0]), .start(st[0]), .tx_data(dat[7:0]),
        .tx(txv[0]), .tx_busy(busyv[0]), .tx_done(donev[0])
`ifdef UART_TX_HOLD_EN
        , .tx_ready(rdy0)
`endif
    );

    uart_tx_frame #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(2), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .b_tick(bt[1]), .start(st[1]), .tx_data(dat[7:0]),
        .tx(txv[1]), .tx_busy(busyv[1]), .tx_done(donev[1])
`ifdef UART_TX_HOLD_EN
        , .tx_ready(rdy1)
`endif
    );

    uart_tx_frame #(.DATA_BITS(7), .OVERSAMPLE(8), .PARITY_MODE(0), .STOP_BITS(1)) dut2 (
        .clk(clk), .rst(rst), .b_tick(bt[2]), .start(st[2]), .tx_data(dat[6:0]),
        .tx(txv[2]), .tx_busy(busyv[2]), .tx_done(donev[2])
`ifdef UART_TX_HOLD_EN
        , .tx_ready(rdy2)
`endif
    );

    // seq lists the line level for each bit period in transmit order, padded with 1s.
    typedef struct {
        int         cfg;
        logic [8:0] data;
        int         nbits;
        logic [0:11] seq;
        int         tperiod;
        int         os;
        int         poke_m;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b want %0b at %0t", nm, act, exp, $time);
        end
    endtask

    // One frame on instance c; ticks arrive on every tp-th edge after the accept edge.
    task automatic run_frame(input int c, input logic [8:0] d, input int nb,
                             input logic [0:11] seq, input int tp, input int os,
                             input int poke_m);
        int p, total;
        p     = tp * os;
        total = nb * p;
        dat   = d;
        st[c] = 1'b1;
        bt[c] = 1'b1;
        @(negedge clk);
        chk("accept_tx", txv[c], 1'b0);
        chk("accept_busy", busyv[c], 1'b1);
        for (int m = 1; m <= total; m++) begin
            bt[c] = (m % tp == 0);
            if (m == poke_m) begin
                st[c] = 1'b1;
                dat   = 9'h03C;
            end else begin
                st[c] = 1'b0;
            end
            @(negedge clk);
            if (m % p == p / 2) chk("mid_bit", txv[c], seq[m / p]);
            if (m == p - 1) chk("start_end", txv[c], 1'b0);
            if (m == p) chk("bit0_begin", txv[c], seq[1]);
            if (m == total - 1) begin
                chk("busy_last", busyv[c], 1'b1);
                chk("done_early", donev[c], 1'b0);
            end
            if (m == total) begin
                chk("done_pulse", donev[c], 1'b1);
                chk("busy_end", busyv[c], 1'b0);
                chk("stop_tx", txv[c], 1'b1);
            end
        end
        bt[c] = 1'b1;
        st[c] = 1'b0;
        @(negedge clk);
        chk("done_once", donev[c], 1'b0);
        chk("idle_busy", busyv[c], 1'b0);
        bt[c] = 1'b0;
    endtask

    initial begin
        int dcnt;
        int bdrop;
        logic [0:11] s11, s22;
        rst = 1'b1;
        st  = '0;
        bt  = '0;
        dat = '0;

        vecs[0] = '{0, 9'h0A5, 10, 12'b010100101111, 1, 16, 0};
        vecs[1] = '{0, 9'h000, 10, 12'b000000000111, 1, 16, 0};
        vecs[2] = '{0, 9'h0FF, 10, 12'b011111111111, 1, 16, 0};
        vecs[3] = '{1, 9'h00F, 12, 12'b011110000011, 1, 16, 0};
        vecs[4] = '{1, 9'h001, 12, 12'b010000000011, 1, 16, 0};
        vecs[5] = '{2, 9'h0D5, 9,  12'b010101011111, 3, 8,  0};
        vecs[6] = '{2, 9'h00E, 9,  12'b001110001111, 3, 8,  0};
        // Parity frame 0x0F: four ones, odd parity bit = 1, then two stop bits.
        vecs[3].seq = 12'b011110000111;

        // Reset and idle
        repeat (3) @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            chk("rst_tx", txv[c], 1'b1);
            chk("rst_busy", busyv[c], 1'b0);
            chk("rst_done", donev[c], 1'b0);
        end
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++)
            run_frame(vecs[i].cfg, vecs[i].data, vecs[i].nbits, vecs[i].seq,
                      vecs[i].tperiod, vecs[i].os, vecs[i].poke_m);

`ifndef UART_TX_HOLD_EN
        // start with 0x3C mid-frame is ignored; the 0xA5 frame completes unchanged
        run_frame(0, 9'h0A5, 10, 12'b010100101111, 1, 16, 40);

        // start held high: one idle cycle after tx_done, then the next frame begins
        dat = 9'h0A5; st[0] = 1'b1; bt[0] = 1'b1;
        @(negedge clk);
        for (int m = 1; m <= 161; m++) begin
            @(negedge clk);
            if (m == 160) begin
                chk("held_done", donev[0], 1'b1);
                chk("held_gap_busy", busyv[0], 1'b0);
                chk("held_gap_tx", txv[0], 1'b1);
            end
            if (m == 161) begin
                chk("held_restart_tx", txv[0], 1'b0);
                chk("held_restart_busy", busyv[0], 1'b1);
                chk("held_restart_done", donev[0], 1'b0);
            end
        end
        st[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("held_rst_busy", busyv[0], 1'b0);
`else
        // Holding register: 0x22 loaded during 0x11 chains with no idle cycle.
        s11 = 12'b010001000111;
        s22 = 12'b001000100111;
        bdrop = 0;
        dat = 9'h011; st[0] = 1'b1; bt[0] = 1'b1;
        @(negedge clk);
        chk("hold_ready_init", rdy0, 1'b1);
        for (int m = 1; m <= 320; m++) begin
            if (m == 30) begin
                st[0] = 1'b1;
                dat   = 9'h022;
            end else begin
                st[0] = 1'b0;
            end
            @(negedge clk);
            if (m < 320 && !busyv[0]) bdrop++;
            if (m == 31) chk("hold_ready_low", rdy0, 1'b0);
            if (m < 160 && m % 16 == 8) chk("hold_f1_bit", txv[0], s11[m / 16]);
            if (m > 160 && (m - 160) % 16 == 8) chk("hold_f2_bit", txv[0], s22[(m - 160) / 16]);
            if (m == 160) begin
                chk("hold_done1", donev[0], 1'b1);
                chk("hold_busy_kept", busyv[0], 1'b1);
                chk("hold_start2", txv[0], 1'b0);
                chk("hold_ready_back", rdy0, 1'b1);
            end
            if (m == 161) chk("hold_done1_once", donev[0], 1'b0);
            if (m == 320) begin
                chk("hold_done2", donev[0], 1'b1);
                chk("hold_busy_end", busyv[0], 1'b0);
            end
        end
        checks++;
        if (bdrop != 0) begin
            failures++;
            $display("FAIL hold_busy_gap: busy low cycles %0d want 0", bdrop);
        end
        bt[0] = 1'b0;
        @(negedge clk);
`endif

        // Reset in DATA aborts: line high, not busy, and no tx_done afterwards
        dat = 9'h0A5; st[0] = 1'b1; bt[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        for (int m = 1; m < 50; m++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_tx", txv[0], 1'b1);
        chk("abort_busy", busyv[0], 1'b0);
        chk("abort_done", donev[0], 1'b0);
        rst = 1'b0;
        dcnt = 0;
        for (int m = 0; m < 200; m++) begin
            @(negedge clk);
            if (donev[0] || busyv[0]) dcnt++;
        end
        checks++;
        if (dcnt != 0) begin
            failures++;
            $display("FAIL abort_quiet: active cycles %0d want 0", dcnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
